multi_debounce: RTL
===================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 The block SHALL have the parameter N_CH, default 4: number of independent button channels, legal range 1..32.
REQ-002 The block SHALL have the parameter STABLE_CYC, default 4: consecutive sampled ticks of disagreement needed to accept a new level, minimum 1.
REQ-003 The block SHALL have the parameter HOLD_CYC, default 8: ticks of continuous press before the first auto-repeat pulse, minimum 1.
REQ-004 The block SHALL have the parameter REPEAT_CYC, default 3: ticks between subsequent auto-repeat pulses, minimum 1.
REQ-005 The block SHALL have the parameter REPEAT_EN, default 1: 1 enables auto-repeat, 0 forces rpt to 0.
REQ-006 The block SHALL have the port clk, input, 1 bit: single clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have the port tick, input, 1 bit: sample strobe; counters advance only when it is 1; tie to 1 for per-clock sampling.
REQ-009 The block SHALL have the port pb, input, N_CH bits: raw asynchronous push-button inputs, one per channel.
REQ-010 The block SHALL have the port db_out, output, N_CH bits: debounced level per channel.
REQ-011 The block SHALL have the port press, output, N_CH bits: one-clock pulse on each debounced 0->1 transition.
REQ-012 The block SHALL have the port release, output, N_CH bits: one-clock pulse on each debounced 1->0 transition.
REQ-013 The block SHALL have the port rpt, output, N_CH bits: one-clock auto-repeat pulse while a channel is held.

Function
REQ-014 Each pb bit SHALL pass through a 2-flop synchronizer clocked every clk, independent of tick.
REQ-015 Each channel SHALL hold a counter cnt of width $clog2(STABLE_CYC+1); on a tick with sync==db_out, cnt clears to 0.
REQ-016 On a tick with sync!=db_out and cnt<STABLE_CYC-1, cnt SHALL increment; at cnt==STABLE_CYC-1, db_out takes sync and cnt clears.
REQ-017 Any single tick on which sync equals db_out SHALL restart the count; glitches shorter than STABLE_CYC ticks never reach db_out.
REQ-018 With tick=1, db_out SHALL change on the (STABLE_CYC+2)th rising edge, counting the first edge that samples the new pb value.
REQ-019 press/release SHALL be registered and asserted for exactly the one clk cycle following the edge at which db_out changes.
REQ-020 Each channel SHALL run a repeat FSM with states IDLE, HOLD and REPEAT, plus a repeat counter rcnt of width $clog2(max(HOLD_CYC,REPEAT_CYC)+1).
REQ-021 The FSM SHALL move IDLE->HOLD on press with rcnt=0.
REQ-022 In HOLD, rcnt SHALL increment per tick; at rcnt==HOLD_CYC-1 the FSM asserts rpt for one cycle, goes to REPEAT and clears rcnt.
REQ-023 In REPEAT, the FSM SHALL assert rpt and clear rcnt each time rcnt reaches REPEAT_CYC-1.
REQ-024 From HOLD or REPEAT, release SHALL force IDLE with rcnt=0 in the same cycle, and no rpt SHALL be issued in the release cycle.
REQ-025 When tick=0, cnt, rcnt and the FSM SHALL hold, and no press/release/rpt SHALL be generated.
REQ-026 When REPEAT_EN=0, the FSM SHALL stay in IDLE and rpt SHALL be 0.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-028 press and rpt SHALL never be asserted on the same channel in the same cycle.

Reset
REQ-029 When rst=1 at a rising edge, all synchronizer flops, cnt, rcnt, db_out, press, release and rpt SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-030 An input held at 1 across reset deassertion SHALL produce press after the normal STABLE_CYC+2 latency.
REQ-031 Reset mid-count or mid-repeat SHALL abort with no pulse emitted.

Structure
REQ-032 The shared package debounce_pkg SHALL hold the FSM state enum (IDLE, HOLD, REPEAT) and the default parameter constants.
REQ-033 The per-channel logic SHALL be the sub-module debounce_ch, covering synchronizer, stability counter, edge pulses and repeat FSM, instantiated N_CH times by generate.

Verification
All scenarios use N_CH=4, STABLE_CYC=4, HOLD_CYC=8, REPEAT_CYC=3, tick=1 unless stated.
REQ-034 Clean press: pb[0] 0->1 and held -> db_out[0]=1 and press[0] pulse at edge 6, with no other channel active.
REQ-035 Glitch: pb[1] high for 3 clk, then low -> db_out[1], press[1] and release[1] stay 0 throughout.
REQ-036 Auto-repeat: pb[2] held for 30 clk -> first rpt 8 clk after press, then every 3 clk; release[2] pulse with no rpt on release.
REQ-037 Tick gating: tick=1 every 4th clk and pb[3] held -> db_out[3] rises after 4 ticks once synchronized, and all pulses are 1 clk wide.
REQ-038 Reset mid-repeat: rst for 1 clk while in REPEAT -> all outputs 0; pb still held -> press re-issued 6 clk after reset release.
REQ-039 Simultaneous: pb[3:0] all rise on the same edge -> press=4'b1111 in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel push-button debouncer:
// repeat FSM state encoding, default parameter values and a constant helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_STABLE_CYC = 4;
    localparam int DEF_HOLD_CYC   = 8;
    localparam int DEF_REPEAT_CYC = 3;
    localparam int DEF_REPEAT_EN  = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, tick-gated stability counter,
// registered press/release pulses and the hold/auto-repeat state machine.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC,
    parameter int REPEAT_EN  = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pb,
    output logic db_out,
    output logic press,
    output logic release_o,
    output logic rpt
);

    localparam int CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int RCNT_W = $clog2(max_int(HOLD_CYC, REPEAT_CYC) + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'(HOLD_CYC - 1);
    localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_CYC - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_db;
    logic              r_press;
    logic              r_release;
    logic              r_rpt;
    logic [RCNT_W-1:0] r_rcnt;
    rpt_state_t        r_state;

    logic w_differ;
    logic w_accept;
    logic w_rise;
    logic w_fall;

    assign w_differ = (r_sync2 != r_db);
    assign w_accept = tick && w_differ && (r_cnt == CNT_LAST);
    assign w_rise   = w_accept && r_sync2;
    assign w_fall   = w_accept && !r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_db      <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= pb;
            r_sync2   <= r_sync1;
            r_press   <= w_rise;
            r_release <= w_fall;
            if (tick) begin
                // A single agreeing tick restarts the count, so short glitches die here.
                if (!w_differ || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_db <= r_sync2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
            r_rpt   <= 1'b0;
        end else begin
            r_rpt <= 1'b0;
            if (REPEAT_EN == 0) begin
                r_state <= IDLE;
                r_rcnt  <= '0;
            end else if (w_fall) begin
                // Release wins over a coinciding repeat tick.
                r_state <= IDLE;
                r_rcnt  <= '0;
            end else if (tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= HOLD;
                            r_rcnt  <= '0;
                        end
                    end
                    HOLD: begin
                        if (r_rcnt == HOLD_LAST) begin
                            r_rpt   <= 1'b1;
                            r_state <= REPEAT;
                            r_rcnt  <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (r_rcnt == REP_LAST) begin
                            r_rpt  <= 1'b1;
                            r_rcnt <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign db_out    = r_db;
    assign press     = r_press;
    assign release_o = r_release;
    assign rpt       = r_rpt;

endmodule

// File: rtl/multi_debounce.sv
// N_CH independent push-button debouncers with press/release pulses and auto-repeat.
// The release pulse port is release_o because "release" is a reserved word.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC,
    parameter int REPEAT_EN  = DEF_REPEAT_EN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] rpt
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_ch #(
                .STABLE_CYC (STABLE_CYC),
                .HOLD_CYC   (HOLD_CYC),
                .REPEAT_CYC (REPEAT_CYC),
                .REPEAT_EN  (REPEAT_EN)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .tick      (tick),
                .pb        (pb[gi]),
                .db_out    (db_out[gi]),
                .press     (press[gi]),
                .release_o (release_o[gi]),
                .rpt       (rpt[gi])
            );
        end
    endgenerate

endmodule
